// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
// Purpose: arbiter FSM state encoding and the supported requester limit.
package mem_arb_pkg;

  localparam int MAX_MASTER = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
// Purpose: choose the first requester after last_grant, wrapping modulo N.
// Ports:
//   req        in  N    request vector
//   last_grant in  IDW  index of the previous owner
//   winner     out IDW  selected index (0 when nothing requests)
//   any_req    out 1    at least one request present
module rr_picker #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [IDW-1:0] winner,
  output logic           any_req
);

  logic found;
  int   idx;

  assign any_req = |req;

  // Scan starting one past the previous owner so the last owner is checked last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter, NR_MASTER requesters onto one memory port
// Purpose: one outstanding transaction; request latched, issued downstream,
//          response passed straight back to the owning master.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   m_req_valid/ready/addr/wen/wdata/wmask   packed per-master requests
//   m_resp_valid/ready, m_resp_rdata          per-master responses, shared data
//   s_req_valid/ready/addr/wen/wdata/wmask   downstream request
//   s_resp_valid/ready/rdata                 downstream response
//   grant_id, busy                           current owner, FSM not idle
module mem_arbiter #(
  parameter int NR_MASTER = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  localparam int IDW      = (NR_MASTER > 1) ? $clog2(NR_MASTER) : 1,
  localparam int MW       = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NR_MASTER-1:0]        m_req_valid,
  output logic [NR_MASTER-1:0]        m_req_ready,
  input  logic [NR_MASTER*ADDR_W-1:0] m_req_addr,
  input  logic [NR_MASTER-1:0]        m_req_wen,
  input  logic [NR_MASTER*DATA_W-1:0] m_req_wdata,
  input  logic [NR_MASTER*MW-1:0]     m_req_wmask,
  output logic [NR_MASTER-1:0]        m_resp_valid,
  output logic [DATA_W-1:0]           m_resp_rdata,
  input  logic [NR_MASTER-1:0]        m_resp_ready,
  output logic                        s_req_valid,
  input  logic                        s_req_ready,
  output logic [ADDR_W-1:0]           s_req_addr,
  output logic                        s_req_wen,
  output logic [DATA_W-1:0]           s_req_wdata,
  output logic [MW-1:0]               s_req_wmask,
  input  logic                        s_resp_valid,
  output logic                        s_resp_ready,
  input  logic [DATA_W-1:0]           s_resp_rdata,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy
);

  import mem_arb_pkg::*;

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MW-1:0]     wmask_q, wmask_d;

  logic [IDW-1:0]    winner;
  logic              any_req;

  rr_picker #(
    .N   (NR_MASTER),
    .IDW (IDW)
  ) u_picker (
    .req        (m_req_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NR_MASTER - 1);
      grant_id_q   <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Next state and payload capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    case (state_q)
      IDLE: begin
        // The winner's ready is raised this cycle, so any request is a handshake.
        if (any_req) begin
          state_d    = ISSUE;
          grant_id_d = winner;
          for (int n = 0; n < NR_MASTER; n++) begin
            if (IDW'(n) == winner) begin
              addr_d  = m_req_addr[n*ADDR_W +: ADDR_W];
              wen_d   = m_req_wen[n];
              wdata_d = m_req_wdata[n*DATA_W +: DATA_W];
              wmask_d = m_req_wmask[n*MW +: MW];
            end
          end
        end
      end
      ISSUE: begin
        if (s_req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (s_resp_valid && m_resp_ready[grant_id_q]) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; forced quiet while rst is high so an abandoned response never leaks.
  always_comb begin
    m_req_ready  = '0;
    m_resp_valid = '0;
    m_resp_rdata = s_resp_rdata;
    s_req_valid  = 1'b0;
    s_resp_ready = 1'b0;
    s_req_addr   = addr_q;
    s_req_wen    = wen_q;
    s_req_wdata  = wdata_q;
    s_req_wmask  = wmask_q;
    grant_id     = grant_id_q;
    busy         = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE:      if (any_req) m_req_ready[winner] = 1'b1;
        ISSUE:     s_req_valid = 1'b1;
        WAIT_RESP: begin
          m_resp_valid[grant_id_q] = s_resp_valid;
          s_resp_ready             = m_resp_ready[grant_id_q];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req_valid;
  logic [1:0]  m_req_ready;
  logic [63:0] m_req_addr;
  logic [1:0]  m_req_wen;
  logic [63:0] m_req_wdata;
  logic [7:0]  m_req_wmask;
  logic [1:0]  m_resp_valid;
  logic [31:0] m_resp_rdata;
  logic [1:0]  m_resp_ready;
  logic        s_req_valid;
  logic        s_req_ready;
  logic [31:0] s_req_addr;
  logic        s_req_wen;
  logic [31:0] s_req_wdata;
  logic [3:0]  s_req_wmask;
  logic        s_resp_valid;
  logic        s_resp_ready;
  logic [31:0] s_resp_rdata;
  logic [0:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A0 = 32'hA000_0010;
  localparam logic [31:0] A1 = 32'hB000_0024;

  mem_arbiter #(.NR_MASTER(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_addr   (m_req_addr),
    .m_req_wen    (m_req_wen),
    .m_req_wdata  (m_req_wdata),
    .m_req_wmask  (m_req_wmask),
    .m_resp_valid (m_resp_valid),
    .m_resp_rdata (m_resp_rdata),
    .m_resp_ready (m_resp_ready),
    .s_req_valid  (s_req_valid),
    .s_req_ready  (s_req_ready),
    .s_req_addr   (s_req_addr),
    .s_req_wen    (s_req_wen),
    .s_req_wdata  (s_req_wdata),
    .s_req_wmask  (s_req_wmask),
    .s_resp_valid (s_resp_valid),
    .s_resp_ready (s_resp_ready),
    .s_resp_rdata (s_resp_rdata),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from IDLE with a zero-wait downstream; ends back in IDLE.
  task automatic run_txn(input int m, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wmask,
                         input logic [31:0] rdata);
    check("grant_ready", {62'd0, m_req_ready}, 64'(2'b01 << m));
    step();
    check("issue_valid", {63'd0, s_req_valid}, 64'd1);
    check("issue_grant", {63'd0, grant_id}, 64'(m));
    check("issue_addr", {32'd0, s_req_addr}, {32'd0, addr});
    check("issue_wen", {63'd0, s_req_wen}, {63'd0, wen});
    check("issue_wdata", {32'd0, s_req_wdata}, {32'd0, wdata});
    check("issue_wmask", {60'd0, s_req_wmask}, {60'd0, wmask});
    check("issue_mready", {62'd0, m_req_ready}, 64'd0);
    check("issue_busy", {63'd0, busy}, 64'd1);
    s_req_ready = 1'b1;
    step();
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b1;
    s_resp_rdata = rdata;
    m_resp_ready = 2'b11;
    #1;
    check("resp_sreqv", {63'd0, s_req_valid}, 64'd0);
    check("resp_valid", {62'd0, m_resp_valid}, 64'(2'b01 << m));
    check("resp_rdata", {32'd0, m_resp_rdata}, {32'd0, rdata});
    check("resp_sready", {63'd0, s_resp_ready}, 64'd1);
    step();
    s_resp_valid = 1'b0;
    #1;
    check("back_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    m_req_valid  = 2'b11;
    m_req_addr   = {A1, A0};
    m_req_wen    = 2'b00;
    m_req_wdata  = 64'h2222_2222_1111_1111;
    m_req_wmask  = 8'hFF;
    m_resp_ready = 2'b00;
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b0;
    s_resp_rdata = 32'h0;
    step();
    step();
    check("rst_mready", {62'd0, m_req_ready}, 64'd0);
    check("rst_sreqv", {63'd0, s_req_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_grant", {63'd0, grant_id}, 64'd0);
    check("rst_addr", {32'd0, s_req_addr}, 64'd0);
    rst = 1'b0;
    #1;

    // Both requesting continuously: strict alternation starting at master 0.
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) run_txn(0, A0, 1'b0, 32'h1111_1111, 4'hF, 32'hC0DE_0000 + 32'(t));
      else            run_txn(1, A1, 1'b0, 32'h2222_2222, 4'hF, 32'hC0DE_0000 + 32'(t));
    end

    // Master 1 alone with downstream stalling three cycles.
    m_req_valid = 2'b10;
    #1;
    check("solo_ready", {62'd0, m_req_ready}, 64'd2);
    step();
    for (int c = 0; c < 3; c++) begin
      check("stall_valid", {63'd0, s_req_valid}, 64'd1);
      check("stall_addr", {32'd0, s_req_addr}, {32'd0, A1});
      check("stall_mready", {62'd0, m_req_ready}, 64'd0);
      step();
    end
    check("stall_still", {63'd0, s_req_valid}, 64'd1);
    s_req_ready = 1'b1;
    step();
    s_req_ready  = 1'b0;
    // Master 1 not ready for its response: downstream must be held.
    s_resp_valid = 1'b1;
    s_resp_rdata = 32'h5555_AAAA;
    m_resp_ready = 2'b01;
    #1;
    check("hold_sready", {63'd0, s_resp_ready}, 64'd0);
    check("hold_mvalid", {62'd0, m_resp_valid}, 64'd2);
    step();
    check("hold_busy", {63'd0, busy}, 64'd1);
    check("hold_mvalid2", {62'd0, m_resp_valid}, 64'd2);
    m_resp_ready = 2'b11;
    #1;
    check("hold_release", {63'd0, s_resp_ready}, 64'd1);
    step();
    s_resp_valid = 1'b0;
    #1;
    check("hold_idle", {63'd0, busy}, 64'd0);

    // Lone requester is granted again immediately.
    run_txn(1, A1, 1'b0, 32'h2222_2222, 4'hF, 32'h0BAD_F00D);

    // Write from master 0.
    m_req_valid = 2'b01;
    m_req_wen   = 2'b01;
    m_req_wdata = 64'h2222_2222_DEAD_BEEF;
    m_req_wmask = 8'hF3;
    #1;
    run_txn(0, A0, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0);

    // Reset in WAIT_RESP abandons the transaction.
    m_req_valid = 2'b10;
    m_req_wen   = 2'b00;
    #1;
    check("pre_rst_ready", {62'd0, m_req_ready}, 64'd2);
    step();
    s_req_ready = 1'b1;
    step();
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b1;
    m_resp_ready = 2'b11;
    rst          = 1'b1;
    #1;
    check("mid_rst_mvalid", {62'd0, m_resp_valid}, 64'd0);
    check("mid_rst_sready", {63'd0, s_resp_ready}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    step();
    rst          = 1'b0;
    s_resp_valid = 1'b0;
    m_req_valid  = 2'b11;
    #1;
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_grant", {63'd0, grant_id}, 64'd0);
    check("post_rst_sreqv", {63'd0, s_req_valid}, 64'd0);
    check("post_rst_addr", {32'd0, s_req_addr}, 64'd0);
    m_req_wdata = 64'h2222_2222_1111_1111;
    m_req_wmask = 8'hFF;
    #1;
    run_txn(0, A0, 1'b0, 32'h1111_1111, 4'hF, 32'h7777_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NR_MASTER, default 2, number of requesters (2..4).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; mask width is DATA_W/8.
REQ-004 Clock: one clock, clk; reset: rst, synchronous, active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 m_req_valid  in  NR_MASTER  per-master request valid.
REQ-008 m_req_ready  out  NR_MASTER  per-master request accept.
REQ-009 m_req_addr  in  NR_MASTER*ADDR_W  packed addresses; master n at [ADDR_W*(n+1)-1 : ADDR_W*n].
REQ-010 m_req_wen  in  NR_MASTER  1=write, 0=read.
REQ-011 m_req_wdata  in  NR_MASTER*DATA_W  packed write data, same packing.
REQ-012 m_req_wmask  in  NR_MASTER*DATA_W/8  packed byte masks.
REQ-013 m_resp_valid  out  NR_MASTER  per-master response valid.
REQ-014 m_resp_rdata  out  DATA_W  shared read data, meaningful only with m_resp_valid.
REQ-015 m_resp_ready  in  NR_MASTER  per-master response accept.
REQ-016 s_req_valid/s_req_ready  out/in  1  downstream request handshake.
REQ-017 s_req_addr, s_req_wen, s_req_wdata, s_req_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  downstream payload.
REQ-018 s_resp_valid/s_resp_ready  in/out  1  downstream response handshake; s_resp_rdata in DATA_W.
REQ-019 grant_id  out  max(1,clog2(NR_MASTER))  index of current owner; busy out 1, high outside IDLE.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT_RESP; one outstanding transaction total.
REQ-021 IDLE: if any m_req_valid, pick winner round-robin starting at last_grant+1 (mod NR_MASTER); assert m_req_ready[winner] only, same cycle, combinationally.
REQ-022 IDLE handshake: latch winner's addr/wen/wdata/wmask and grant_id; next state ISSUE. No valid: stay IDLE, all m_req_ready 0.
REQ-023 ISSUE: s_req_valid=1 with latched payload, stable until s_req_ready; on handshake go WAIT_RESP.
REQ-024 WAIT_RESP: m_resp_valid[grant_id]=s_resp_valid, m_resp_rdata=s_resp_rdata, s_resp_ready=m_resp_ready[grant_id]; other m_resp_valid 0.
REQ-025 WAIT_RESP handshake (s_resp_valid & s_resp_ready): last_grant<=grant_id, go IDLE.
REQ-026 Minimum latency: master accept cycle N, s_req_valid cycle N+1, response passthrough zero-cycle, next accept earliest cycle after response handshake.
REQ-027 s_resp_valid in IDLE or ISSUE is ignored; s_resp_ready is 0 there.
REQ-028 m_req_ready is 0 in ISSUE and WAIT_RESP for all masters; requests held by masters until granted.
REQ-029 Single active requester re-granted back-to-back; no starvation: any asserted requester granted within NR_MASTER transactions.
REQ-030 Writes also require a response handshake (rdata don't-care).

Reset
REQ-031 On rst: state IDLE, last_grant=NR_MASTER-1 (master 0 first), grant_id=0, latched payload 0.
REQ-032 During/after reset cycle: s_req_valid=0, s_resp_ready=0, m_req_ready=0, m_resp_valid=0, busy=0.
REQ-033 rst mid-transaction abandons it; no response forwarded; downstream must be reset in the same cycle.

Structure
REQ-034 Package mem_arb_pkg holds state enum (IDLE/ISSUE/WAIT_RESP) and MAX_MASTER=4 constant.
REQ-035 One sub-module rr_picker: inputs request vector, last_grant; outputs winner index, any_req; purely combinational.

Verification
REQ-036 Reset, m_req_valid=2'b11 -> master 0 granted first, then master 1; s_req_addr matches each.
REQ-037 Both masters continuously requesting, 6 transactions -> grant sequence 0,1,0,1,0,1.
REQ-038 Master 1 alone, s_req_ready held low 3 cycles -> s_req_valid held 3 cycles, payload stable, m_req_ready all 0.
REQ-039 Write 0xDEADBEEF mask 4'b0011 from master 0 -> s_req_wen=1, wdata/wmask exact; m_resp_valid[0] only.
REQ-040 m_resp_ready[1]=0 with s_resp_valid=1 -> s_resp_ready=0, stays WAIT_RESP until ready.
REQ-041 rst asserted in WAIT_RESP -> next cycle IDLE, all outputs zero, master 0 gets next grant.
